// File: rtl/interpolate_if.sv
// Sample-strobe bundle between the sample source and the interpolator.
// master drives samples in; slave is the interpolator.
interface interpolate_if #(
    parameter int DATA_IN_BITS       = 17,
    parameter int DATA_OUT_BITS      = 17,
    parameter int INTERPOLATION_BITS = 5
);
    logic                          data_in_ready;
    logic [DATA_IN_BITS-1:0]       data_in;
    logic                          data_out_ready;
    logic [DATA_OUT_BITS-1:0]      data_out;
    logic [INTERPOLATION_BITS-1:0] phase;
    logic                          busy;
    logic                          overrun;

    modport master (
        output data_in_ready, data_in,
        input  data_out_ready, data_out, phase, busy, overrun
    );

    modport slave (
        input  data_in_ready, data_in,
        output data_out_ready, data_out, phase, busy, overrun
    );
endinterface

// File: rtl/interpolate.sv
// Sample-rate interpolator: each input sample is re-emitted INTERPOLATION_NUM times,
// OUT_PERIOD clocks apart, with a 1-deep pending buffer and overrun pulse.
//
//  state | meaning
//  IDLE  | no sample in flight; next data_in_ready starts phase 0 on the following cycle
//  RUN   | emitting phases of cur; pace_cnt counts down to the next strobe
module interpolate #(
    parameter int DATA_IN_BITS       = 17,
    parameter int DATA_OUT_BITS      = 17,
    parameter int INTERPOLATION_NUM  = 32,
    parameter int INTERPOLATION_BITS = 5,
    parameter int OUT_PERIOD         = 4,
    parameter int PERIOD_BITS        = 3,
    parameter int ZERO_STUFF         = 0
) (
    input logic          clk,
    input logic          rst,
    interpolate_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [INTERPOLATION_BITS-1:0] PHASE_LAST =
        INTERPOLATION_BITS'(INTERPOLATION_NUM - 1);
    localparam logic [PERIOD_BITS-1:0] PACE_LOAD = PERIOD_BITS'(OUT_PERIOD - 1);

    state_t                   state;
    logic [PERIOD_BITS-1:0]   pace_cnt;
    logic [DATA_IN_BITS-1:0]  cur;
    logic [DATA_IN_BITS-1:0]  pend;
    logic                     pend_valid;
    logic [DATA_IN_BITS-1:0]  next_sample;
    logic [DATA_OUT_BITS-1:0] next_wide;
    logic                     pace_done;
    logic                     decide;

    assign pace_done = (state == RUN) && (pace_cnt == '0);
    // Decision cycle: one full period after the last phase strobe of cur.
    assign decide    = pace_done && (bus.phase == PHASE_LAST);

    always_comb begin
        next_sample = cur;
        if (state == IDLE) begin
            next_sample = bus.data_in;
        end else if (decide) begin
            next_sample = pend_valid ? pend : bus.data_in;
        end
    end

    generate
        if (DATA_OUT_BITS > DATA_IN_BITS) begin : g_sext
            assign next_wide = {{(DATA_OUT_BITS-DATA_IN_BITS){next_sample[DATA_IN_BITS-1]}},
                                next_sample};
        end else if (DATA_OUT_BITS == DATA_IN_BITS) begin : g_same
            assign next_wide = next_sample;
        end else begin : g_trunc
            logic unused_lsbs;
            assign unused_lsbs = ^next_sample[DATA_IN_BITS-DATA_OUT_BITS-1:0];
            assign next_wide   = next_sample[DATA_IN_BITS-1 -: DATA_OUT_BITS];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            pace_cnt           <= '0;
            cur                <= '0;
            pend               <= '0;
            pend_valid         <= 1'b0;
            bus.data_out_ready <= 1'b0;
            bus.data_out       <= '0;
            bus.phase          <= '0;
            bus.busy           <= 1'b0;
            bus.overrun        <= 1'b0;
        end else begin
            bus.data_out_ready <= 1'b0;
            bus.overrun        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_in_ready) begin
                        state              <= RUN;
                        cur                <= bus.data_in;
                        pace_cnt           <= PACE_LOAD;
                        bus.data_out_ready <= 1'b1;
                        bus.data_out       <= next_wide;
                        bus.phase          <= '0;
                        bus.busy           <= 1'b1;
                    end
                end
                RUN: begin
                    if (!pace_done) begin
                        pace_cnt <= pace_cnt - PERIOD_BITS'(1);
                    end
                    if (decide) begin
                        if (pend_valid || bus.data_in_ready) begin
                            cur                <= next_sample;
                            pace_cnt           <= PACE_LOAD;
                            bus.data_out_ready <= 1'b1;
                            bus.data_out       <= next_wide;
                            bus.phase          <= '0;
                            // Pending promoted while a new sample arrives: it refills pending, no overrun.
                            pend_valid         <= pend_valid && bus.data_in_ready;
                            if (pend_valid && bus.data_in_ready) begin
                                pend <= bus.data_in;
                            end
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        if (pace_done) begin
                            pace_cnt           <= PACE_LOAD;
                            bus.data_out_ready <= 1'b1;
                            bus.phase          <= bus.phase + INTERPOLATION_BITS'(1);
                            bus.data_out       <= (ZERO_STUFF != 0) ? '0 : next_wide;
                        end
                        if (bus.data_in_ready) begin
                            pend       <= bus.data_in;
                            pend_valid <= 1'b1;
                            if (pend_valid) begin
                                bus.overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interpolate.sv
// Scoreboard bench for interpolate: a block-schedule model predicts strobes, overruns and busy;
// four DUT variants (hold, zero-stuff, 20-bit and 12-bit outputs) share one stimulus stream.
module tb_interpolate;
    localparam int N  = 4;
    localparam int P  = 3;
    localparam int NP = N * P;

    typedef struct {
        int          t;
        int          ph;
        logic [16:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din_rdy = 1'b0;
    logic [16:0] din = '0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   blk_q[$];
    int   d_last = -1000;
    bit   pend_v = 1'b0;
    logic [16:0] pend_d = '0;

    int          last_ph = 0;
    logic [16:0] last_v = '0;
    exp_t        e;
    bit          exp_now;
    bit          exp_ovr;
    bit          busy_exp;
    bit          any_rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interpolate_if #(.DATA_IN_BITS(17), .DATA_OUT_BITS(17), .INTERPOLATION_BITS(2)) if_main ();
    interpolate_if #(.DATA_IN_BITS(17), .DATA_OUT_BITS(17), .INTERPOLATION_BITS(2)) if_zs ();
    interpolate_if #(.DATA_IN_BITS(17), .DATA_OUT_BITS(20), .INTERPOLATION_BITS(2)) if_w20 ();
    interpolate_if #(.DATA_IN_BITS(17), .DATA_OUT_BITS(12), .INTERPOLATION_BITS(2)) if_w12 ();

    assign if_main.data_in_ready = din_rdy;
    assign if_main.data_in       = din;
    assign if_zs.data_in_ready   = din_rdy;
    assign if_zs.data_in         = din;
    assign if_w20.data_in_ready  = din_rdy;
    assign if_w20.data_in        = din;
    assign if_w12.data_in_ready  = din_rdy;
    assign if_w12.data_in        = din;

    interpolate #(.DATA_IN_BITS(17), .DATA_OUT_BITS(17), .INTERPOLATION_NUM(N),
                  .INTERPOLATION_BITS(2), .OUT_PERIOD(P), .PERIOD_BITS(2), .ZERO_STUFF(0))
        u_main (.clk(clk), .rst(rst), .bus(if_main));
    interpolate #(.DATA_IN_BITS(17), .DATA_OUT_BITS(17), .INTERPOLATION_NUM(N),
                  .INTERPOLATION_BITS(2), .OUT_PERIOD(P), .PERIOD_BITS(2), .ZERO_STUFF(1))
        u_zs (.clk(clk), .rst(rst), .bus(if_zs));
    interpolate #(.DATA_IN_BITS(17), .DATA_OUT_BITS(20), .INTERPOLATION_NUM(N),
                  .INTERPOLATION_BITS(2), .OUT_PERIOD(P), .PERIOD_BITS(2), .ZERO_STUFF(0))
        u_w20 (.clk(clk), .rst(rst), .bus(if_w20));
    interpolate #(.DATA_IN_BITS(17), .DATA_OUT_BITS(12), .INTERPOLATION_NUM(N),
                  .INTERPOLATION_BITS(2), .OUT_PERIOD(P), .PERIOD_BITS(2), .ZERO_STUFF(0))
        u_w12 (.clk(clk), .rst(rst), .bus(if_w12));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // A committed block: sample v plays phases 0..N-1 starting at cycle s, busy through s+NP-1.
    task automatic commit(input int s, input logic [16:0] v);
        for (int k = 0; k < N; k++) exp_q.push_back('{s + k * P, k, v});
        blk_q.push_back(s);
        d_last = s - 1 + NP;
    endtask

    task automatic advance(input int c);
        while (pend_v && d_last <= c) begin
            pend_v = 1'b0;
            commit(d_last + 1, pend_d);
        end
    endtask

    task automatic model_in(input int c, input logic [16:0] v);
        advance(c);
        if (c >= d_last) begin
            commit(c + 1, v);
        end else if (!pend_v) begin
            pend_v = 1'b1;
            pend_d = v;
        end else begin
            pend_d = v;
            ovr_q.push_back(c + 1);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ovr_q.delete();
        blk_q.delete();
        pend_v  = 1'b0;
        d_last  = -1000;
        last_ph = 0;
        last_v  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        advance(cyc);
    endtask

    task automatic drive_at(input int t, input logic [16:0] v);
        while (cyc < t) tick();
        din_rdy = 1'b1;
        din     = v;
        model_in(cyc, v);
        tick();
        din_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend_v || exp_q.size() != 0 || cyc <= d_last + 1) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("idle_timeout", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, if_main.data_out_ready, 0);
        check({tag, "_data"}, if_main.data_out, 0);
        check({tag, "_phase"}, if_main.phase, 0);
        check({tag, "_busy"}, if_main.busy, 0);
        check({tag, "_overrun"}, if_main.overrun, 0);
        check({tag, "_w20_data"}, if_w20.data_out, 0);
        check({tag, "_w12_data"}, if_w12.data_out, 0);
    endtask

    always @(negedge clk) begin
        exp_now = (exp_q.size() != 0) && (exp_q[0].t == cyc);
        if (exp_now) begin
            e       = exp_q.pop_front();
            last_ph = e.ph;
            last_v  = e.v;
        end
        any_rdy = if_main.data_out_ready | if_zs.data_out_ready |
                  if_w20.data_out_ready | if_w12.data_out_ready;
        if (exp_now || any_rdy) begin
            check("strobe", if_main.data_out_ready, exp_now);
            check("zs_strobe", if_zs.data_out_ready, exp_now);
            check("w20_strobe", if_w20.data_out_ready, exp_now);
            check("w12_strobe", if_w12.data_out_ready, exp_now);
        end
        check("phase", if_main.phase, last_ph);
        check("data_out", if_main.data_out, last_v);
        check("zs_data", if_zs.data_out, (last_ph == 0) ? last_v : 17'h0);
        check("w20_data", if_w20.data_out, {{3{last_v[16]}}, last_v});
        check("w12_data", if_w12.data_out, last_v[16:5]);

        while (blk_q.size() != 0 && blk_q[0] + NP - 1 < cyc) void'(blk_q.pop_front());
        busy_exp = (blk_q.size() != 0) && (blk_q[0] <= cyc);
        check("busy", if_main.busy, busy_exp);

        exp_ovr = (ovr_q.size() != 0) && (ovr_q[0] == cyc);
        if (exp_ovr || if_main.overrun) check("overrun", if_main.overrun, exp_ovr);
        if (exp_ovr) void'(ovr_q.pop_front());
    end

    initial begin
        int base;
        int gap;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();

        base = cyc;
        drive_at(base + 10, 17'h00123);
        wait_idle();

        base = cyc;
        drive_at(base + 10, 17'h00005);
        drive_at(base + 22, 17'h1FFF9);
        wait_idle();

        base = cyc;
        drive_at(base + 10, 17'h00001);
        drive_at(base + 12, 17'h00002);
        drive_at(base + 13, 17'h00003);
        wait_idle();

        base = cyc;
        drive_at(base + 5, 17'h0FFFF);
        drive_at(base + 17, 17'h10000);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       gap = NP;
                1:       gap = $urandom_range(1, NP - 1);
                2:       gap = $urandom_range(NP + 1, NP + 8);
                default: gap = $urandom_range(1, 3);
            endcase
            drive_at(cyc + gap - 1, 17'($urandom));
        end
        wait_idle();

        drive_at(cyc + 2, 17'h0ABCD);
        drive_at(cyc + 3, 17'h1F00F);
        repeat (4) tick();
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("midrun_reset");
        repeat (2) tick();
        rst = 1'b1;
        repeat (30) tick();
        drive_at(cyc + 2, 17'h04321);
        wait_idle();

        check("exp_q_drained", exp_q.size(), 0);
        check("ovr_q_drained", ovr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
